// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered mux with manual select and one-shot auto-scan sweep.
// Define MUX_CHMASK_EN to add the ch_en per-channel scan enable mask.
module mux_scan_n #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 1,
    parameter int unsigned SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] d,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic           start,
`ifdef MUX_CHMASK_EN
    input  logic [N-1:0]   ch_en,
`endif
    output logic [W-1:0]   y,
    output logic [SW-1:0]  ch,
    output logic           y_valid,
    output logic           busy,
    output logic           done
);
    localparam int unsigned   CW       = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  y_nxt;
    logic [SW-1:0] ch_nxt;
    logic          y_valid_nxt, busy_nxt, done_nxt;
    logic [N-1:0]  en;
    logic          first_ok, next_ok;
    logic [SW-1:0] first_idx, next_idx;

`ifdef MUX_CHMASK_EN
    assign en = ch_en;
`else
    assign en = '1;
`endif

    // Channel slice by index; out-of-range indices read as zero.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus, input logic [SW-1:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (s == SW'(i)) r = bus[i*W +: W];
        end
        return r;
    endfunction

    // Lowest enabled channel overall, and lowest enabled channel above idx.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (en[i]) begin
                first_ok  = 1'b1;
                first_idx = SW'(i);
            end
            if (en[i] && (SW'(i) > idx)) begin
                next_ok  = 1'b1;
                next_idx = SW'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        y_nxt       = y;
        ch_nxt      = ch;
        y_valid_nxt = 1'b0;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (!mode) begin
                    y_nxt       = pick(d, sel);
                    ch_nxt      = sel;
                    y_valid_nxt = (32'(sel) < N);
                end else if (start) begin
                    if (first_ok) begin
                        state_nxt = SCAN;
                        idx_nxt   = first_idx;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b1;
                    end else begin
                        // Empty mask: report an immediately finished sweep.
                        done_nxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                y_nxt  = pick(d, idx);
                ch_nxt = idx;
                if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    cnt_nxt     = '0;
                    y_valid_nxt = 1'b1;
                    if (next_ok) begin
                        idx_nxt = next_idx;
                    end else begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            y       <= '0;
            ch      <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            y       <= y_nxt;
            ch      <= ch_nxt;
            y_valid <= y_valid_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomized bench for mux_scan_n (N=6, W=4, DWELL=3) against a sweep-level reference model.
module tb_mux_scan_n;
    localparam int unsigned N  = 6;
    localparam int unsigned W  = 4;
    localparam int unsigned DWELL = 3;
    localparam int unsigned SW = 3;
    localparam int          DW = int'(DWELL);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] d = '0;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic           start = 1'b0;
    logic [N-1:0]   en_m = '1;
    logic [W-1:0]   y;
    logic [SW-1:0]  ch;
    logic           y_valid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int chans[$];

    always #5 clk = ~clk;

    mux_scan_n #(.N(N), .W(W), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .sel(sel), .start(start),
`ifdef MUX_CHMASK_EN
        .ch_en(en_m),
`endif
        .y(y), .ch(ch), .y_valid(y_valid), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] v, input int c);
        return v[c*W +: W];
    endfunction

    function automatic logic [N*W-1:0] rand_d();
        return (N*W)'($urandom);
    endfunction

    // Channel visit order: every enabled channel, ascending, once.
    task automatic build_chans();
        chans.delete();
        for (int i = 0; i < int'(N); i++) if (en_m[i]) chans.push_back(i);
    endtask

    function automatic logic [N-1:0] pick_mask();
`ifdef MUX_CHMASK_EN
        return N'($urandom_range(1, (1 << N) - 1));
`else
        return '1;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; sel = '0; start = 1'b0; d = '0;
        #2;
        n_tests++;
        if ({y, ch, y_valid, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got y=%h ch=%0d v=%b busy=%b done=%b, want all 0",
                     y, ch, y_valid, busy, done);
        end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_manual();
`ifdef MUX_CHMASK_EN
        en_m = '0;
`endif
        mode = 1'b0;
        for (int i = 0; i < 14; i++) begin
            sel = (i < int'(N)) ? SW'(i) : SW'($urandom_range(0, N - 1));
            d = rand_d();
            step();
            n_tests++;
            if ({y, ch, y_valid, busy, done} !== {slice_of(d, int'(sel)), sel, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL manual sel=%0d: got y=%h ch=%0d v=%b b=%b dn=%b, want y=%h ch=%0d v=1",
                         sel, y, ch, y_valid, busy, done, slice_of(d, int'(sel)), sel);
            end
        end
    endtask

    task automatic test_out_of_range();
        mode = 1'b0;
        for (int s = int'(N); s < 8; s++) begin
            sel = SW'(s);
            d = rand_d();
            step();
            n_tests++;
            if ({y, ch, y_valid} !== {{W{1'b0}}, SW'(s), 1'b0}) begin
                n_fail++;
                $display("FAIL out_of_range sel=%0d: got y=%h ch=%0d v=%b, want y=0 ch=%0d v=0",
                         s, y, ch, y_valid, s);
            end
        end
        sel = SW'(N - 1);
        step();
        n_tests++;
        if ({y, ch, y_valid} !== {slice_of(d, int'(N) - 1), SW'(N - 1), 1'b1}) begin
            n_fail++;
            $display("FAIL range_recover: got y=%h ch=%0d v=%b, want y=%h ch=%0d v=1",
                     y, ch, y_valid, slice_of(d, int'(N) - 1), N - 1);
        end
    endtask

    task automatic test_idle_hold();
        logic [W-1:0] hy;
        mode = 1'b0; sel = 3'd2; d = rand_d();
        step();
        hy = slice_of(d, 2);
        mode = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = rand_d();
            step();
            n_tests++;
            if ({y, ch, y_valid, busy, done} !== {hy, 3'd2, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_hold: got y=%h ch=%0d v=%b b=%b dn=%b, want y=%h ch=2 v=0 b=0 dn=0",
                         y, ch, y_valid, busy, done, hy);
            end
        end
    endtask

    task automatic test_scan();
        int total;
        for (int sw = 0; sw < 3; sw++) begin
            en_m = pick_mask();
            build_chans();
            total = chans.size() * DW;
            mode = 1'b1; start = 1'b1; d = rand_d();
            step();
            n_tests++;
            if ({y_valid, busy, done} !== 3'b010) begin
                n_fail++;
                $display("FAIL scan_start: got v=%b b=%b dn=%b, want v=0 b=1 dn=0", y_valid, busy, done);
            end
            // Mode, select and start are ignored mid-sweep.
            start = 1'b0; mode = 1'b0; sel = SW'($urandom_range(0, N - 1));
            for (int c = 1; c <= total; c++) begin
                if (c == 2) start = 1'b1;
                if (c == 3) start = 1'b0;
                d = rand_d();
                step();
                n_tests++;
                if ({y, ch, y_valid, busy, done} !==
                    {slice_of(d, chans[(c - 1) / DW]), SW'(chans[(c - 1) / DW]),
                     (c % DW) == 0, c != total, c == total}) begin
                    n_fail++;
                    $display("FAIL scan c=%0d: got y=%h ch=%0d v=%b b=%b dn=%b, want y=%h ch=%0d v=%b b=%b dn=%b",
                             c, y, ch, y_valid, busy, done, slice_of(d, chans[(c - 1) / DW]),
                             chans[(c - 1) / DW], (c % DW) == 0, c != total, c == total);
                end
            end
            d = rand_d();
            step();
            n_tests++;
            if ({y, ch, y_valid, busy, done} !== {slice_of(d, int'(sel)), sel, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL scan_after: got y=%h ch=%0d v=%b b=%b dn=%b, want manual y=%h ch=%0d v=1",
                         y, ch, y_valid, busy, done, slice_of(d, int'(sel)), sel);
            end
        end
    endtask

    task automatic test_back_to_back();
        int total;
        logic [W-1:0] last_y;
        en_m = pick_mask();
        build_chans();
        total = chans.size() * DW;
        mode = 1'b1; start = 1'b1;
        for (int sw = 0; sw < 2; sw++) begin
            last_y = y;
            d = rand_d();
            step();
            n_tests++;
            if (sw == 1 && {y, y_valid, busy, done} !== {last_y, 3'b010}) begin
                n_fail++;
                $display("FAIL b2b_restart: got y=%h v=%b b=%b dn=%b, want y=%h v=0 b=1 dn=0",
                         y, y_valid, busy, done, last_y);
            end else if (sw == 0 && {y_valid, busy, done} !== 3'b010) begin
                n_fail++;
                $display("FAIL b2b_start: got v=%b b=%b dn=%b, want v=0 b=1 dn=0", y_valid, busy, done);
            end
            for (int c = 1; c <= total; c++) begin
                d = rand_d();
                step();
                n_tests++;
                if ({y, ch, y_valid, busy, done} !==
                    {slice_of(d, chans[(c - 1) / DW]), SW'(chans[(c - 1) / DW]),
                     (c % DW) == 0, c != total, c == total}) begin
                    n_fail++;
                    $display("FAIL b2b sweep=%0d c=%0d: got y=%h ch=%0d v=%b b=%b dn=%b, want ch=%0d v=%b b=%b dn=%b",
                             sw, c, y, ch, y_valid, busy, done, chans[(c - 1) / DW],
                             (c % DW) == 0, c != total, c == total);
                end
            end
        end
        start = 1'b0;
        step();
        n_tests++;
        if ({y_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_stop: got v=%b b=%b dn=%b, want 0 0 0", y_valid, busy, done);
        end
    endtask

`ifdef MUX_CHMASK_EN
    task automatic test_empty_mask();
        en_m = '0; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if ({y_valid, busy, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL empty_mask: got v=%b b=%b dn=%b, want v=0 b=0 dn=1", y_valid, busy, done);
        end
        step();
        n_tests++;
        if ({y_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL empty_mask_after: got v=%b b=%b dn=%b, want 0 0 0", y_valid, busy, done);
        end
    endtask
`endif

    task automatic test_reset_mid_sweep();
        bit hit;
        hit = 1'b0;
        en_m = '1; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            d = rand_d();
            step();
            if (busy && ch == 3'd4) hit = 1'b1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got no ch=4 within 40 cycles, want ch=4 while busy");
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({y, ch, y_valid, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got y=%h ch=%0d v=%b b=%b dn=%b, want all 0",
                     y, ch, y_valid, busy, done);
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({y, ch, y_valid, busy, done} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: got y=%h ch=%0d v=%b b=%b dn=%b, want idle all 0",
                         y, ch, y_valid, busy, done);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_manual();
        test_out_of_range();
        test_idle_hold();
        test_scan();
        test_back_to_back();
`ifdef MUX_CHMASK_EN
        test_empty_mask();
`endif
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
